serial_subtractor: RTL

//   Bit-serial WIDTH-bit subtractor computing diff = a - b.

---
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first,
//            one bit per clock through a borrow chain.
// Options  : SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] a_sh_q,       a_sh_d;
  logic [WIDTH-1:0] b_sh_q,       b_sh_d;
  logic [WIDTH-1:0] res_q,        res_d;
  logic             bor_q,        bor_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q,      a_msb_d;
  logic             b_msb_q,      b_msb_d;
  logic             ovf_q,        ovf_d;
`endif

  logic w_x;
  logic w_y;
  logic w_bit;
  logic w_bor_next;
  logic [WIDTH-1:0] w_res_next;

  always_comb begin
    w_x        = a_sh_q[0];
    w_y        = b_sh_q[0];
    w_bit      = w_x ^ w_y ^ bor_q;
    w_bor_next = (~w_x & w_y) | (~(w_x ^ w_y) & bor_q);
    w_res_next = {w_bit, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    bor_d        = bor_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = w_res_next;
        bor_d  = w_bor_next;
        if (cnt_q == CNT_LAST) begin
          // Results are published only here so they hold across later runs.
          state_d      = S_DONE;
          diff_d       = w_res_next;
          borrow_out_d = w_bor_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d        = (a_msb_q ^ b_msb_q) & (a_msb_q ^ w_bit);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      bor_q        <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      bor_q        <= bor_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule
`default_nettype wire
